round_judge: RTL and testbench

ROUND_JUDGE -- requirements
Module: round_judge

---
 rtl/round_judge_pkg.sv | 61 ++++++
 rtl/round_judge_if.sv | 27 ++
 rtl/round_judge_key_debounce.sv | 49 ++++
 rtl/round_judge.sv | 135 +++++++++++++
 tb/tb_round_judge.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/round_judge_pkg.sv
// Shared encodings for the rock-paper-scissors style animal judge:
// choice codes, FSM states, scenario bit positions and the outcome/rule decode.
package round_judge_pkg;

   localparam logic [2:0] CAT     = 3'b001;
   localparam logic [2:0] DOG     = 3'b010;
   localparam logic [2:0] CHICKEN = 3'b100;

   typedef enum logic [2:0] {
      P1_WAIT = 3'd0,
      P2_WAIT = 3'd1,
      SHOW    = 3'd2,
      SCORE   = 3'd3,
      OVER    = 3'd4
   } state_t;

   // Scenario bit positions, player 1 choice first, MSB = catCat.
   localparam int unsigned SC_CAT_CAT         = 32'd8;
   localparam int unsigned SC_CAT_DOG         = 32'd7;
   localparam int unsigned SC_CAT_CHICKEN     = 32'd6;
   localparam int unsigned SC_DOG_CAT         = 32'd5;
   localparam int unsigned SC_DOG_DOG         = 32'd4;
   localparam int unsigned SC_DOG_CHICKEN     = 32'd3;
   localparam int unsigned SC_CHICKEN_CAT     = 32'd2;
   localparam int unsigned SC_CHICKEN_DOG     = 32'd1;
   localparam int unsigned SC_CHICKEN_CHICKEN = 32'd0;

   function automatic logic is_one_hot(input logic [2:0] c);
      return (c == CAT) || (c == DOG) || (c == CHICKEN);
   endfunction

   function automatic logic [8:0] decode_scenario(input logic [2:0] c1, input logic [2:0] c2);
      logic [8:0] s;
      s = 9'b0;
      case ({c1, c2})
         {CAT, CAT}:         s[SC_CAT_CAT]         = 1'b1;
         {CAT, DOG}:         s[SC_CAT_DOG]         = 1'b1;
         {CAT, CHICKEN}:     s[SC_CAT_CHICKEN]     = 1'b1;
         {DOG, CAT}:         s[SC_DOG_CAT]         = 1'b1;
         {DOG, DOG}:         s[SC_DOG_DOG]         = 1'b1;
         {DOG, CHICKEN}:     s[SC_DOG_CHICKEN]     = 1'b1;
         {CHICKEN, CAT}:     s[SC_CHICKEN_CAT]     = 1'b1;
         {CHICKEN, DOG}:     s[SC_CHICKEN_DOG]     = 1'b1;
         {CHICKEN, CHICKEN}: s[SC_CHICKEN_CHICKEN] = 1'b1;
         default:            s = 9'b0;
      endcase
      return s;
   endfunction

   // Returns {player2 wins, player1 wins}; 2'b00 on a draw.
   function automatic logic [1:0] judge(input logic [2:0] c1, input logic [2:0] c2);
      logic [1:0] r;
      case ({c1, c2})
         {DOG, CAT}, {CAT, CHICKEN}, {CHICKEN, DOG}: r = 2'b01;
         {CAT, DOG}, {CHICKEN, CAT}, {DOG, CHICKEN}: r = 2'b10;
         default:                                     r = 2'b00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/round_judge_if.sv
// Player/drawing-side signal bundle of round_judge; the judge is the slave.
interface round_judge_if;
   logic [2:0] sw_choice;
   logic       key_n;
   logic       draw_done;
   logic [8:0] scenario;
   logic       scenario_valid;
   logic       winner1;
   logic       winner2;
   logic [3:0] player1;
   logic [3:0] player2;
   logic [1:0] awaiting;
   logic       invalid;
   logic       match_over;

   modport master (
      output sw_choice, key_n, draw_done,
      input  scenario, scenario_valid, winner1, winner2,
      input  player1, player2, awaiting, invalid, match_over
   );

   modport slave (
      input  sw_choice, key_n, draw_done,
      output scenario, scenario_valid, winner1, winner2,
      output player1, player2, awaiting, invalid, match_over
   );
endinterface

// File: rtl/round_judge_key_debounce.sv
// Two-flop synchronizer plus symmetric debouncer for the active-low confirm key;
// emits one press pulse per stable low period.
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic resetn,
   input  logic key_n,
   output logic press
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 32'd1) ? $clog2(DEBOUNCE_CYCLES) : 32'd1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

   logic             sync1_r;
   logic             sync2_r;
   logic             armed_r;
   logic             press_r;
   logic [CNT_W-1:0] cnt_r;

   // Armed: count low cycles toward a press; disarmed: count high cycles toward re-arm.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         armed_r <= 1'b1;
         press_r <= 1'b0;
         cnt_r   <= '0;
      end else begin
         sync1_r <= key_n;
         sync2_r <= sync1_r;
         press_r <= 1'b0;
         if (armed_r == !sync2_r) begin
            if (cnt_r == CNT_LAST) begin
               press_r <= armed_r;
               armed_r <= !armed_r;
               cnt_r   <= '0;
            end else begin
               cnt_r <= cnt_r + 1'b1;
            end
         end else begin
            cnt_r <= '0;
         end
      end
   end

   assign press = press_r;

endmodule

// File: rtl/round_judge.sv
// Two-player animal judge: collects both choices via the debounced key, shows
// the outcome until the drawing controller is done, then scores the round.
module round_judge
   import round_judge_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned WIN_SCORE       = 5
) (
   input logic          clk,
   input logic          resetn,
   round_judge_if.slave bus
);

   localparam logic [3:0] WIN_VAL = 4'(WIN_SCORE);

   state_t     state_r;
   logic [2:0] choice1_r;
   logic [2:0] choice2_r;
   logic [3:0] player1_r;
   logic [3:0] player2_r;
   logic [8:0] scenario_r;
   logic       scenario_valid_r;
   logic       winner1_r;
   logic       winner2_r;
   logic       invalid_r;
   logic       match_over_r;
   logic [1:0] awaiting_r;
   logic       press_s;
   logic [1:0] win_s;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .clk    (clk),
      .resetn (resetn),
      .key_n  (bus.key_n),
      .press  (press_s)
   );

   // Round result from the latched choices.
   always_comb begin
      win_s = judge(choice1_r, choice2_r);
   end

   // Round FSM with all outputs registered.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r          <= P1_WAIT;
         choice1_r        <= 3'b000;
         choice2_r        <= 3'b000;
         player1_r        <= 4'd0;
         player2_r        <= 4'd0;
         scenario_r       <= 9'b0;
         scenario_valid_r <= 1'b0;
         winner1_r        <= 1'b0;
         winner2_r        <= 1'b0;
         invalid_r        <= 1'b0;
         match_over_r     <= 1'b0;
         awaiting_r       <= 2'b01;
      end else begin
         winner1_r <= 1'b0;
         winner2_r <= 1'b0;
         invalid_r <= 1'b0;
         case (state_r)
            P1_WAIT: begin
               if (press_s) begin
                  if (is_one_hot(bus.sw_choice)) begin
                     choice1_r  <= bus.sw_choice;
                     state_r    <= P2_WAIT;
                     awaiting_r <= 2'b10;
                  end else begin
                     invalid_r <= 1'b1;
                  end
               end
            end
            P2_WAIT: begin
               if (press_s) begin
                  if (is_one_hot(bus.sw_choice)) begin
                     choice2_r        <= bus.sw_choice;
                     state_r          <= SHOW;
                     awaiting_r       <= 2'b00;
                     scenario_r       <= decode_scenario(choice1_r, bus.sw_choice);
                     scenario_valid_r <= 1'b1;
                  end else begin
                     invalid_r <= 1'b1;
                  end
               end
            end
            SHOW: begin
               // Score lands together with the winner pulse on entry to SCORE.
               if (bus.draw_done) begin
                  state_r          <= SCORE;
                  scenario_r       <= 9'b0;
                  scenario_valid_r <= 1'b0;
                  winner1_r        <= win_s[0];
                  winner2_r        <= win_s[1];
                  if (win_s[0] && (player1_r < WIN_VAL)) begin
                     player1_r <= player1_r + 4'd1;
                  end
                  if (win_s[1] && (player2_r < WIN_VAL)) begin
                     player2_r <= player2_r + 4'd1;
                  end
               end
            end
            SCORE: begin
               if ((player1_r == WIN_VAL) || (player2_r == WIN_VAL)) begin
                  state_r      <= OVER;
                  match_over_r <= 1'b1;
               end else begin
                  state_r    <= P1_WAIT;
                  awaiting_r <= 2'b01;
               end
            end
            OVER: begin
               state_r <= OVER;
            end
            default: begin
               state_r          <= P1_WAIT;
               awaiting_r       <= 2'b01;
               scenario_r       <= 9'b0;
               scenario_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.scenario       = scenario_r;
   assign bus.scenario_valid = scenario_valid_r;
   assign bus.winner1        = winner1_r;
   assign bus.winner2        = winner2_r;
   assign bus.player1        = player1_r;
   assign bus.player2        = player2_r;
   assign bus.awaiting       = awaiting_r;
   assign bus.invalid        = invalid_r;
   assign bus.match_over     = match_over_r;

endmodule

// File: tb/tb_round_judge.sv
// Scoreboard bench for round_judge: directed scenarios then random matches,
// expected events come from an arithmetic rock-paper-scissors model.
module tb_round_judge;

   localparam int WIN = 3;
   localparam logic [2:0] B_CAT = 3'b001;
   localparam logic [2:0] B_DOG = 3'b010;
   localparam logic [2:0] B_CHK = 3'b100;

   logic clk    = 1'b0;
   logic resetn = 1'b1;
   always #5 clk = ~clk;

   round_judge_if bus();

   round_judge #(.DEBOUNCE_CYCLES(4), .WIN_SCORE(WIN)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef enum int {EV_INVALID = 0, EV_SHOW = 1, EV_WIN = 2, EV_OVER = 3} ev_kind_t;
   typedef struct {
      ev_kind_t   kind;
      logic [8:0] scen;
      logic [1:0] win;
      int         s1;
      int         s2;
   } ev_t;
   ev_t exp_q[$];

   // Reference model: stage 0 = wait P1, 1 = wait P2, 2 = showing.
   int m_p1, m_p2, m_stage, m_c1, m_c2;
   bit m_over;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int idx(input logic [2:0] c);
      if (c == B_CAT) return 0;
      if (c == B_DOG) return 1;
      return 2;
   endfunction

   function automatic int exp_await();
      if (m_over) return 0;
      if (m_stage == 0) return 1;
      if (m_stage == 1) return 2;
      return 0;
   endfunction

   task automatic push_ev(input ev_kind_t k, input logic [8:0] sc, input logic [1:0] w);
      ev_t e;
      e.kind = k; e.scen = sc; e.win = w; e.s1 = m_p1; e.s2 = m_p2;
      exp_q.push_back(e);
   endtask

   task automatic model_reset();
      m_p1 = 0; m_p2 = 0; m_stage = 0; m_over = 1'b0; m_c1 = 0; m_c2 = 0;
      exp_q.delete();
   endtask

   task automatic model_press(input logic [2:0] sw);
      logic [8:0] one9;
      one9 = 9'd1;
      if (!m_over && m_stage != 2) begin
         if ($countones(sw) != 1) begin
            push_ev(EV_INVALID, 9'd0, 2'b00);
         end else if (m_stage == 0) begin
            m_c1 = idx(sw); m_stage = 1;
         end else begin
            m_c2 = idx(sw); m_stage = 2;
            push_ev(EV_SHOW, one9 << (8 - 3 * m_c1 - m_c2), 2'b00);
         end
      end
   endtask

   task automatic model_draw();
      int d;
      logic [1:0] w;
      if (!m_over && m_stage == 2) begin
         d = (m_c1 - m_c2 + 3) % 3;
         w = 2'b00;
         if (d == 1) begin m_p1++; w = 2'b01; end
         else if (d == 2) begin m_p2++; w = 2'b10; end
         if (w != 2'b00) push_ev(EV_WIN, 9'd0, w);
         m_stage = 0;
         if (m_p1 == WIN || m_p2 == WIN) begin
            m_over = 1'b1;
            push_ev(EV_OVER, 9'd0, 2'b00);
         end
      end
   endtask

   task automatic key_press(input logic [2:0] sw);
      @(negedge clk);
      bus.sw_choice = sw;
      bus.key_n = 1'b0;
      repeat (8) @(negedge clk);
      bus.key_n = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   task automatic press(input logic [2:0] sw);
      model_press(sw);
      key_press(sw);
   endtask

   task automatic draw_pulse();
      model_draw();
      @(negedge clk);
      bus.draw_done = 1'b1;
      @(negedge clk);
      bus.draw_done = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic check_state(input string tag);
      check({tag, " awaiting"}, bus.awaiting, exp_await());
      check({tag, " player1"}, bus.player1, m_p1);
      check({tag, " player2"}, bus.player2, m_p2);
      check({tag, " match_over"}, bus.match_over, m_over);
   endtask

   task automatic play_round(input logic [2:0] c1, input logic [2:0] c2);
      press(c1);
      check("p1 press awaiting", bus.awaiting, exp_await());
      press(c2);
      check("p2 press valid", bus.scenario_valid, m_over ? 0 : 1);
      draw_pulse();
      check_state("round");
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " scenario"}, bus.scenario, 0);
      check({tag, " scenario_valid"}, bus.scenario_valid, 0);
      check({tag, " winners"}, {bus.winner1, bus.winner2}, 0);
      check({tag, " invalid"}, bus.invalid, 0);
      check({tag, " match_over"}, bus.match_over, 0);
      check({tag, " awaiting"}, bus.awaiting, 1);
      check({tag, " scores"}, {bus.player1, bus.player2}, 0);
   endtask

   task automatic apply_reset(input string tag);
      @(negedge clk);
      resetn = 1'b0;
      model_reset();
      #1;
      check_reset_values(tag);
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic expect_ev(input ev_kind_t k);
      ev_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected event: got kind %0d expected none (t=%0t)", k, $time);
      end else begin
         e = exp_q.pop_front();
         check("event kind", k, e.kind);
         if (e.kind == k && k == EV_SHOW) check("show scenario", bus.scenario, e.scen);
         if (e.kind == k && k == EV_WIN) begin
            check("winner bits", {bus.winner2, bus.winner1}, e.win);
            check("win player1", bus.player1, e.s1);
            check("win player2", bus.player2, e.s2);
         end
      end
   endtask

   // Monitor: turns DUT output activity into events and pops the scoreboard.
   logic prev_sv = 1'b0;
   logic prev_mo = 1'b0;
   always @(negedge clk) begin
      if (resetn !== 1'b1) begin
         prev_sv <= 1'b0;
         prev_mo <= 1'b0;
      end else begin
         if (bus.invalid) expect_ev(EV_INVALID);
         if (bus.scenario_valid && !prev_sv) expect_ev(EV_SHOW);
         if (bus.winner1 || bus.winner2) expect_ev(EV_WIN);
         if (bus.match_over && !prev_mo) expect_ev(EV_OVER);
         if (!bus.scenario_valid) check("idle scenario zero", bus.scenario, 0);
         prev_sv <= bus.scenario_valid;
         prev_mo <= bus.match_over;
      end
   end

   task automatic random_step();
      logic [2:0] bad [5];
      logic [2:0] good [3];
      int a;
      bad[0] = 3'b000; bad[1] = 3'b011; bad[2] = 3'b101; bad[3] = 3'b110; bad[4] = 3'b111;
      good[0] = B_CAT; good[1] = B_DOG; good[2] = B_CHK;
      a = $urandom_range(0, 5);
      if (m_stage == 2) begin
         if (a == 0) press(good[$urandom_range(0, 2)]);
         draw_pulse();
      end else if (a == 0) begin
         press(bad[$urandom_range(0, 4)]);
      end else if (a == 1) begin
         draw_pulse();
      end else begin
         press(good[$urandom_range(0, 2)]);
      end
      check_state("random");
   endtask

   initial begin
      bus.sw_choice = 3'b000;
      bus.key_n     = 1'b1;
      bus.draw_done = 1'b0;
      model_reset();
      #1 resetn = 1'b0;
      #1;
      check_reset_values("power-on reset");
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      repeat (4) @(negedge clk);

      // Basic round: dog beats cat.
      press(B_DOG);
      press(B_CAT);
      check("basic scenario", bus.scenario, 9'b000100000);
      draw_pulse();
      check("basic player1", bus.player1, 1);
      check("basic player2", bus.player2, 0);
      check("basic awaiting", bus.awaiting, 1);

      // Draw.
      press(B_CHK);
      press(B_CHK);
      check("draw scenario", bus.scenario, 9'b000000001);
      draw_pulse();
      check_state("draw");

      // Invalid choice then valid.
      press(3'b011);
      check("invalid awaiting", bus.awaiting, 1);
      press(B_CAT);
      check("after valid awaiting", bus.awaiting, 2);
      press(B_DOG);
      draw_pulse();
      check_state("cat-dog");

      // Bounce: low 3, high 1, low 10 gives one press.
      model_press(3'b011);
      @(negedge clk);
      bus.sw_choice = 3'b011;
      bus.key_n = 1'b0; repeat (3) @(negedge clk);
      bus.key_n = 1'b1; repeat (1) @(negedge clk);
      bus.key_n = 1'b0; repeat (10) @(negedge clk);
      bus.key_n = 1'b1; repeat (12) @(negedge clk);
      check("bounce awaiting", bus.awaiting, 1);
      check("bounce one invalid", exp_q.size(), 0);

      // Long hold: one press only.
      model_press(B_DOG);
      @(negedge clk);
      bus.sw_choice = B_DOG;
      bus.key_n = 1'b0; repeat (100) @(negedge clk);
      bus.key_n = 1'b1; repeat (12) @(negedge clk);
      check("hold awaiting", bus.awaiting, 2);
      check("hold no show", bus.scenario_valid, 0);
      press(B_CHK);
      draw_pulse();
      check_state("dog-chicken");

      // Reset mid-SHOW abandons the round.
      press(B_CAT);
      press(B_DOG);
      check("pre-reset show", bus.scenario_valid, 1);
      apply_reset("mid-show reset");
      draw_pulse();
      check_state("post-reset draw_done");

      // Player 2 wins the match.
      repeat (3) play_round(B_DOG, B_CHK);
      check("match player2", bus.player2, 3);
      check("match player1", bus.player1, 0);
      check("match over", bus.match_over, 1);
      press(B_CAT);
      press(B_DOG);
      draw_pulse();
      check_state("over frozen");
      check("over no show", bus.scenario_valid, 0);

      // Random matches.
      for (int m = 0; m < 3; m++) begin
         apply_reset("random reset");
         for (int r = 0; r < 80 && !m_over; r++) random_step();
         check("random reached end", m_over, 1);
         press(B_CHK);
         draw_pulse();
         check_state("random over frozen");
      end

      repeat (5) @(negedge clk);
      check("scoreboard drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
